// File: rtl/mac_accumulator.sv
// Per-lane accumulator behind the dual-lane partial-sum adder. It sums a programmed
// number of beats, then presents either both lanes or their reduced sum.
module mac_accumulator #(
    parameter int LEN_W = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             reduce_i,
    input  logic [63:0]      sums_i,
    input  logic             sums_valid_i,
    output logic             sums_ready_o,
    output logic [63:0]      res_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             busy_o,
    output logic [1:0]       ovf_o
);

    // Handshakes: a beat moves when sums_valid_i & sums_ready_o are both high at
    // a rising edge; the result is taken when res_valid_o & res_ready_i are high.
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc0_q, acc1_q;
    logic [LEN_W-1:0] cnt_q;
    logic             reduce_q;

    logic             beat, last_beat;
    logic [32:0]      sum0, sum1, red;

    // Returns {overflow, result}; the 33-bit sum's top bit gives the true sign.
    function automatic logic [32:0] add_lane(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) begin
            if (SAT) add_lane = {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
            else     add_lane = {1'b1, s[31:0]};
        end else begin
            add_lane = {1'b0, s[31:0]};
        end
    endfunction

    always_comb begin
        beat      = (state_q == ACC) && sums_valid_i;
        last_beat = beat && (cnt_q == LEN_W'(1));
        sum0      = add_lane(acc0_q, sums_i[31:0]);
        sum1      = add_lane(acc1_q, sums_i[63:32]);
        // Reduction sees the final accumulator values, including the last beat.
        red       = add_lane(sum0[31:0], sum1[31:0]);
    end

    always_comb begin
        state_d      = state_q;
        sums_ready_o = 1'b0;
        busy_o       = (state_q != IDLE);
        case (state_q)
            IDLE: if (start_i) state_d = (len_i == '0) ? DONE : ACC;
            ACC: begin
                sums_ready_o = 1'b1;
                if (last_beat) state_d = DONE;
            end
            DONE: if (res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc0_q      <= '0;
            acc1_q      <= '0;
            cnt_q       <= '0;
            reduce_q    <= 1'b0;
            res_o       <= '0;
            res_valid_o <= 1'b0;
            ovf_o       <= 2'b00;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        acc0_q   <= '0;
                        acc1_q   <= '0;
                        ovf_o    <= 2'b00;
                        cnt_q    <= len_i;
                        reduce_q <= reduce_i;
                        if (len_i == '0) begin
                            res_o       <= '0;
                            res_valid_o <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc0_q <= sum0[31:0];
                        acc1_q <= sum1[31:0];
                        cnt_q  <= cnt_q - 1'b1;
                        ovf_o  <= ovf_o | {sum1[32], sum0[32] | (last_beat & reduce_q & red[32])};
                        if (last_beat) begin
                            res_valid_o <= 1'b1;
                            if (reduce_q) res_o <= {{32{red[31]}}, red[31:0]};
                            else          res_o <= {sum1[31:0], sum0[31:0]};
                        end
                    end
                end
                DONE: if (res_ready_i) res_valid_o <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a saturating and a wrapping instance share
// stimulus, and each result is compared with hand-computed values.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        reduce;
    logic [63:0] sums;
    logic        sums_valid;
    logic        res_ready;

    logic        s_sums_ready, s_res_valid, s_busy;
    logic [63:0] s_res;
    logic [1:0]  s_ovf;
    logic        w_sums_ready, w_res_valid, w_busy;
    logic [63:0] w_res;
    logic [1:0]  w_ovf;

    int n_cmp = 0;
    int n_err = 0;
    int beats_taken = 0;
    int ready_cycles = 0;

    always #5 clk = ~clk;

    mac_accumulator #(.LEN_W(8), .SAT(1'b1)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .reduce_i(reduce),
        .sums_i(sums), .sums_valid_i(sums_valid), .sums_ready_o(s_sums_ready),
        .res_o(s_res), .res_valid_o(s_res_valid), .res_ready_i(res_ready),
        .busy_o(s_busy), .ovf_o(s_ovf)
    );

    mac_accumulator #(.LEN_W(8), .SAT(1'b0)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .reduce_i(reduce),
        .sums_i(sums), .sums_valid_i(sums_valid), .sums_ready_o(w_sums_ready),
        .res_o(w_res), .res_valid_o(w_res_valid), .res_ready_i(res_ready),
        .busy_o(w_busy), .ovf_o(w_ovf)
    );

    always @(posedge clk) begin
        if (sums_valid && s_sums_ready) beats_taken++;
        if (s_sums_ready) ready_cycles++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] l, input logic r);
        start  = 1'b1;
        len    = l;
        reduce = r;
        tick();
        start  = 1'b0;
        beats_taken  = 0;
        ready_cycles = 0;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    logic [63:0] held_res;

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; reduce = 1'b0;
        sums = '0; sums_valid = 1'b0; res_ready = 1'b0;
        #12;
        check("reset_res", s_res, 64'h0);
        check("reset_flags", {59'd0, s_sums_ready, s_res_valid, s_busy, s_ovf}, 64'h0);
        rst = 1'b0;
        tick();

        // Basic two-lane job with valid held high
        start_job(8'd3, 1'b0);
        sums_valid = 1'b1;
        sums = {32'd5, 32'd1};           tick();
        sums = {-32'sd2, 32'd2};         tick();
        sums = {32'd7, 32'd3};           tick();
        check("basic_res", s_res, {32'd10, 32'd6});
        check("basic_valid_ready", {62'd0, s_res_valid, s_sums_ready}, 64'h2);
        check("basic_ovf", {62'd0, s_ovf}, 64'h0);
        sums = 64'hDEAD_BEEF_0BAD_F00D;  tick();
        check("basic_beats", 64'(beats_taken), 64'd3);
        check("basic_ready_cycles", 64'(ready_cycles), 64'd3);
        sums_valid = 1'b0;
        release_result();
        check("basic_idle", {62'd0, s_res_valid, s_busy}, 64'h0);
        check("basic_res_kept", s_res, {32'd10, 32'd6});

        // Reduce with bubbles: (-40+1) + (100-1) = 60
        start_job(8'd2, 1'b1);
        sums_valid = 1'b1;
        sums = {32'd100, -32'sd40};      tick();
        sums_valid = 1'b0;               tick(); tick();
        check("reduce_not_done", {63'd0, s_res_valid}, 64'h0);
        sums_valid = 1'b1;
        sums = {-32'sd1, 32'd1};         tick();
        sums_valid = 1'b0;
        check("reduce_res", s_res, 64'h0000_0000_0000_003C);
        check("reduce_valid", {63'd0, s_res_valid}, 64'h1);
        check("reduce_beats", 64'(beats_taken), 64'd2);
        release_result();

        // Saturation vs wrap on lane 0
        start_job(8'd2, 1'b0);
        sums_valid = 1'b1;
        sums = {32'd0, 32'h7FFF_FFF0};   tick();
        sums = {32'd0, 32'h0000_0020};   tick();
        sums_valid = 1'b0;
        check("sat_res", s_res, {32'd0, 32'h7FFF_FFFF});
        check("sat_ovf", {62'd0, s_ovf}, 64'h1);
        check("wrap_res", w_res, {32'd0, 32'h8000_0010});
        check("wrap_ovf", {62'd0, w_ovf}, 64'h1);
        release_result();

        // Zero length: straight to DONE, valid beats ignored
        sums_valid = 1'b1;
        sums = {32'd9, 32'd9};
        start_job(8'd0, 1'b0);
        check("zero_res", s_res, 64'h0);
        check("zero_flags", {61'd0, s_res_valid, s_busy, s_sums_ready}, 64'h6);
        tick();
        check("zero_beats", 64'(beats_taken), 64'd0);
        sums_valid = 1'b0;
        release_result();

        // Back-pressure with a start pulse during DONE
        start_job(8'd1, 1'b0);
        check("bp_ovf_cleared", {62'd0, s_ovf}, 64'h0);
        sums_valid = 1'b1;
        sums = {-32'sd3, 32'd4};         tick();
        sums_valid = 1'b0;
        held_res = {-32'sd3, 32'd4};
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            len   = 8'd5;
            check("bp_res_hold", s_res, held_res);
            check("bp_valid_hold", {62'd0, s_res_valid, s_busy}, 64'h3);
            tick();
        end
        start = 1'b0;
        release_result();
        check("bp_idle", {62'd0, s_res_valid, s_busy}, 64'h0);
        tick();
        check("bp_start_ignored", {62'd0, s_busy, s_sums_ready}, 64'h0);

        // Asynchronous reset mid-job, then a fresh job
        start_job(8'd4, 1'b0);
        sums_valid = 1'b1;
        sums = {32'd9, 32'd9};           tick();
        sums_valid = 1'b0;
        check("pre_reset_busy", {63'd0, s_busy}, 64'h1);
        #2 rst = 1'b1;
        #1;
        check("async_res", s_res, 64'h0);
        check("async_flags", {59'd0, s_sums_ready, s_res_valid, s_busy, s_ovf}, 64'h0);
        rst = 1'b0;
        tick();
        start_job(8'd1, 1'b0);
        sums_valid = 1'b1;
        sums = {32'd1, 32'd1};           tick();
        sums_valid = 1'b0;
        check("post_reset_res", s_res, {32'd1, 32'd1});
        check("post_reset_valid", {63'd0, s_res_valid}, 64'h1);
        release_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
